state_controller: RTL and testbench
===================================

// Module: state_controller
// PURPOSE
//  AHB-Lite slave control FSM for the USB endpoint register block. Samples the
//  address phase (hsel/htrans/haddr/hwrite/hsize), decodes the 7-bit address map
//  and drives the data phase: buffer strobes, transfer size and hready/hresp.
//  Sits between the AHB bus interface and the data buffer / status registers.
// PARAMETERS
//  none (address map fixed below)
// PORTS
//  clk             in   1  system clock, rising-edge
//  nRst            in   1  reset: one clock; reset is asynchronous and active-high
//  haddr           in   7  AHB address
//  htrans          in   2  AHB transfer type; 2'b00 = no transfer
//  hsize           in   2  AHB size: 00 byte, 01 half, 10 word, 11 illegal
//  hwrite          in   1  1 = write, 0 = read
//  hsel            in   1  slave select
//  state           out  2  FSM state: 00 IDLE, 01 WRITE, 10 READ, 11 ERROR
//  storeTxData     out  1  data-phase strobe: write into data buffer
//  getRxData       out  1  data-phase strobe: read from data buffer
//  hresp           out  1  AHB response, 1 = ERROR
//  hready          out  1  AHB ready, 0 = stall
//  dataSize        out  2  registered hsize of the current data phase
//  bufferReserved  out  1  data buffer busy with a bus access
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, strobes 0, hresp 0, hready 1,
//    dataSize 0, bufferReserved 0. Reset mid-transfer aborts to IDLE at once.
//  - Request valid when hsel=1 and htrans!=00. Decode sampled each rising edge;
//    response appears one cycle later (data phase).
//  - Address map:
//      0x00-0x3F data buffer, R/W, any legal size
//      0x40-0x47 status registers, read-only
//      0x48      control register, R/W
//      0x49-0x7F unmapped
//  - Error request: hsize=11, write to 0x40-0x47, or any access to 0x49-0x7F.
//  - Next state from IDLE/WRITE/READ (back-to-back transfers allowed):
//      no valid request -> IDLE; error request -> ERROR;
//      legal write -> WRITE; legal read -> READ.
//  - ERROR lasts exactly one cycle, then IDLE unconditionally; inputs sampled
//    during ERROR are ignored. Re-evaluate from IDLE on the next edge.
//  - WRITE: storeTxData=1 only if address 0x00-0x3F, else 0.
//  - READ: getRxData=1 only if address 0x00-0x3F, else 0.
//  - ERROR: hresp=1, hready=0. All other states: hresp=0, hready=1.
//  - Strobes are 0 in IDLE and ERROR. Only one strobe is active at a time.
//  - dataSize: loads hsize on every valid request, errors included; holds
//    otherwise.
//  - bufferReserved = registered (storeTxData | getRxData).
// TESTING
//  - Reset: assert nRst 2 cycles, release
//      -> IDLE, hready=1, hresp=0, strobes 0, dataSize 0.
//  - Writes 0x00/sz10, 0x23/sz00, 0x3F/sz01 (hsel=1, htrans=01)
//      -> next cycle state=01, storeTxData=1, dataSize=hsize.
//  - Write 0x48/sz00 -> state=01, storeTxData=0, hresp=0.
//  - Reads 0x00/sz10, 0x23, 0x3F -> state=10, getRxData=1.
//    Reads 0x41, 0x42/sz01, 0x44, 0x48 -> state=10, getRxData=0.
//  - Error requests -> state=11, hresp=1, hready=0, then IDLE next cycle:
//    write 0x15/sz11, write 0x48/sz11, write 0x43/sz00.
//  - Back-to-back write->read->idle (hsel=0)
//      -> WRITE, READ, IDLE on consecutive cycles.

Source files
------------

// File: rtl/state_controller.sv
// ----------------------------------------------------------------------------
// state_controller
//   AHB-Lite slave control FSM for the USB endpoint register block. Samples
//   the address phase, decodes the 7-bit address map and drives the data
//   phase: buffer strobes, transfer size and hready/hresp. All outputs are
//   registered, so the response appears one cycle after the address phase.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no transfer in data phase
//   WRITE | legal write in data phase (strobe only for buffer range)
//   READ  | legal read in data phase (strobe only for buffer range)
//   ERROR | one-cycle error response; inputs sampled here are ignored
//
// Ports
//   clk            in   system clock, rising edge
//   nRst           in   asynchronous reset, active-high (despite the name)
//   haddr[6:0]     in   AHB address
//   htrans[1:0]    in   AHB transfer type, 00 = no transfer
//   hsize[1:0]     in   AHB size, 11 is illegal
//   hwrite         in   1 = write, 0 = read
//   hsel           in   slave select
//   state[1:0]     out  00 IDLE, 01 WRITE, 10 READ, 11 ERROR
//   storeTxData    out  write strobe into the data buffer
//   getRxData      out  read strobe from the data buffer
//   hresp          out  1 = ERROR response
//   hready         out  0 = stall
//   dataSize[1:0]  out  hsize of the current data phase
//   bufferReserved out  strobe activity delayed by one cycle
// ----------------------------------------------------------------------------
module state_controller (
  input  logic       clk,
  input  logic       nRst,
  input  logic [6:0] haddr,
  input  logic [1:0] htrans,
  input  logic [1:0] hsize,
  input  logic       hwrite,
  input  logic       hsel,
  output logic [1:0] state,
  output logic       storeTxData,
  output logic       getRxData,
  output logic       hresp,
  output logic       hready,
  output logic [1:0] dataSize,
  output logic       bufferReserved
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10,
    ERROR = 2'b11
  } state_t;

  state_t     cur_state;
  state_t     nxt_state;
  logic       nxt_store;
  logic       nxt_get;
  logic [1:0] nxt_size;

  logic valid_req;
  logic in_buffer;
  logic in_status;
  logic unmapped;
  logic err_req;

  // Address decode: 0x00-0x3F buffer, 0x40-0x47 status, 0x48 control,
  // 0x49-0x7F unmapped.
  assign valid_req = hsel && (htrans != 2'b00);
  assign in_buffer = (haddr[6] == 1'b0);
  assign in_status = (haddr[6:3] == 4'b1000);
  assign unmapped  = (haddr > 7'h48);
  assign err_req   = (hsize == 2'b11) || (hwrite && in_status) || unmapped;

  always_comb begin
    nxt_state = IDLE;
    nxt_store = 1'b0;
    nxt_get   = 1'b0;
    nxt_size  = dataSize;
    // ERROR always returns to IDLE and ignores the bus, including hsize.
    if (cur_state != ERROR && valid_req) begin
      nxt_size = hsize;
      if (err_req) begin
        nxt_state = ERROR;
      end else if (hwrite) begin
        nxt_state = WRITE;
        nxt_store = in_buffer;
      end else begin
        nxt_state = READ;
        nxt_get   = in_buffer;
      end
    end
  end

  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      cur_state      <= IDLE;
      storeTxData    <= 1'b0;
      getRxData      <= 1'b0;
      hresp          <= 1'b0;
      hready         <= 1'b1;
      dataSize       <= 2'b00;
      bufferReserved <= 1'b0;
    end else begin
      cur_state      <= nxt_state;
      storeTxData    <= nxt_store;
      getRxData      <= nxt_get;
      hresp          <= (nxt_state == ERROR);
      hready         <= (nxt_state != ERROR);
      dataSize       <= nxt_size;
      bufferReserved <= storeTxData | getRxData;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_state_controller.sv
module tb_state_controller;

  logic       clk;
  logic       nRst;
  logic [6:0] haddr;
  logic [1:0] htrans;
  logic [1:0] hsize;
  logic       hwrite;
  logic       hsel;
  logic [1:0] state;
  logic       storeTxData;
  logic       getRxData;
  logic       hresp;
  logic       hready;
  logic [1:0] dataSize;
  logic       bufferReserved;

  int n_cmp = 0;
  int n_err = 0;

  state_controller dut (
    .clk(clk),
    .nRst(nRst),
    .haddr(haddr),
    .htrans(htrans),
    .hsize(hsize),
    .hwrite(hwrite),
    .hsel(hsel),
    .state(state),
    .storeTxData(storeTxData),
    .getRxData(getRxData),
    .hresp(hresp),
    .hready(hready),
    .dataSize(dataSize),
    .bufferReserved(bufferReserved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic stx,
                         input logic grx, input logic rsp, input logic rdy,
                         input logic [1:0] ds, input logic br);
    chk({tag, ".state"},  {6'd0, state},          {6'd0, st});
    chk({tag, ".store"},  {7'd0, storeTxData},    {7'd0, stx});
    chk({tag, ".get"},    {7'd0, getRxData},      {7'd0, grx});
    chk({tag, ".hresp"},  {7'd0, hresp},          {7'd0, rsp});
    chk({tag, ".hready"}, {7'd0, hready},         {7'd0, rdy});
    chk({tag, ".size"},   {6'd0, dataSize},       {6'd0, ds});
    chk({tag, ".resv"},   {7'd0, bufferReserved}, {7'd0, br});
  endtask

  // Present one address phase at the falling edge, let a rising edge sample
  // it, then observe the data phase at the next falling edge.
  task automatic step(input logic sel, input logic [1:0] tr, input logic [6:0] a,
                      input logic wr, input logic [1:0] sz);
    hsel   = sel;
    htrans = tr;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    nRst = 1'b1; hsel = 0; htrans = 0; haddr = 0; hwrite = 0; hsize = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    nRst = 1'b0;
    chk_all("reset", 2'b00, 0, 0, 0, 1, 2'd0, 0);

    // buffer writes
    step(1, 2'b01, 7'h00, 1, 2'b10); chk_all("wr00", 2'b01, 1, 0, 0, 1, 2'd2, 0);
    step(1, 2'b01, 7'h23, 1, 2'b00); chk_all("wr23", 2'b01, 1, 0, 0, 1, 2'd0, 1);
    step(1, 2'b01, 7'h3F, 1, 2'b01); chk_all("wr3f", 2'b01, 1, 0, 0, 1, 2'd1, 1);
    // control register write: legal, no buffer strobe
    step(1, 2'b01, 7'h48, 1, 2'b00); chk_all("wr48", 2'b01, 0, 0, 0, 1, 2'd0, 1);

    // buffer reads
    step(1, 2'b01, 7'h00, 0, 2'b10); chk_all("rd00", 2'b10, 0, 1, 0, 1, 2'd2, 0);
    step(1, 2'b01, 7'h23, 0, 2'b10); chk_all("rd23", 2'b10, 0, 1, 0, 1, 2'd2, 1);
    step(1, 2'b01, 7'h3F, 0, 2'b10); chk_all("rd3f", 2'b10, 0, 1, 0, 1, 2'd2, 1);
    // status / control reads: legal, no buffer strobe
    step(1, 2'b01, 7'h41, 0, 2'b10); chk_all("rd41", 2'b10, 0, 0, 0, 1, 2'd2, 1);
    step(1, 2'b01, 7'h42, 0, 2'b01); chk_all("rd42", 2'b10, 0, 0, 0, 1, 2'd1, 0);
    step(1, 2'b01, 7'h44, 0, 2'b10); chk_all("rd44", 2'b10, 0, 0, 0, 1, 2'd2, 0);
    step(1, 2'b01, 7'h48, 0, 2'b00); chk_all("rd48", 2'b10, 0, 0, 0, 1, 2'd0, 0);

    // no transfer: hsel low, then hsel high with htrans=00; dataSize holds
    step(0, 2'b01, 7'h00, 1, 2'b11); chk_all("idle_nosel", 2'b00, 0, 0, 0, 1, 2'd0, 0);
    step(1, 2'b00, 7'h00, 1, 2'b10); chk_all("idle_notr", 2'b00, 0, 0, 0, 1, 2'd0, 0);

    // errors; a legal write offered during ERROR must be ignored
    step(1, 2'b01, 7'h15, 1, 2'b11); chk_all("err_sz", 2'b11, 0, 0, 1, 0, 2'd3, 0);
    step(1, 2'b01, 7'h10, 1, 2'b10); chk_all("err_sz_exit", 2'b00, 0, 0, 0, 1, 2'd3, 0);
    step(1, 2'b01, 7'h48, 1, 2'b11); chk_all("err_ctl_sz", 2'b11, 0, 0, 1, 0, 2'd3, 0);
    step(0, 2'b00, 7'h00, 0, 2'b00); chk_all("err_ctl_exit", 2'b00, 0, 0, 0, 1, 2'd3, 0);
    step(1, 2'b01, 7'h43, 1, 2'b00); chk_all("err_stwr", 2'b11, 0, 0, 1, 0, 2'd0, 0);
    step(0, 2'b00, 7'h00, 0, 2'b00); chk_all("err_stwr_exit", 2'b00, 0, 0, 0, 1, 2'd0, 0);
    step(1, 2'b01, 7'h49, 0, 2'b01); chk_all("err_unmap49", 2'b11, 0, 0, 1, 0, 2'd1, 0);
    step(1, 2'b01, 7'h7F, 0, 2'b10); chk_all("err_unmap_exit", 2'b00, 0, 0, 0, 1, 2'd1, 0);
    step(1, 2'b01, 7'h47, 0, 2'b10); chk_all("rd47", 2'b10, 0, 0, 0, 1, 2'd2, 0);
    step(1, 2'b01, 7'h40, 1, 2'b10); chk_all("err_wr40", 2'b11, 0, 0, 1, 0, 2'd2, 0);

    // back-to-back write -> read -> idle
    step(0, 2'b00, 7'h00, 0, 2'b00); chk_all("b2b_pre", 2'b00, 0, 0, 0, 1, 2'd2, 0);
    step(1, 2'b10, 7'h10, 1, 2'b10); chk_all("b2b_wr", 2'b01, 1, 0, 0, 1, 2'd2, 0);
    step(1, 2'b11, 7'h11, 0, 2'b01); chk_all("b2b_rd", 2'b10, 0, 1, 0, 1, 2'd1, 1);
    step(0, 2'b00, 7'h00, 0, 2'b00); chk_all("b2b_idle", 2'b00, 0, 0, 0, 1, 2'd1, 1);
    step(0, 2'b00, 7'h00, 0, 2'b00); chk_all("b2b_idle2", 2'b00, 0, 0, 0, 1, 2'd1, 0);

    // asynchronous reset in the middle of a write data phase
    step(1, 2'b01, 7'h05, 1, 2'b10); chk_all("pre_rst", 2'b01, 1, 0, 0, 1, 2'd2, 0);
    #2 nRst = 1'b1;
    #1 chk_all("async_rst", 2'b00, 0, 0, 0, 1, 2'd0, 0);
    @(negedge clk);
    nRst = 1'b0;
    step(1, 2'b01, 7'h3F, 0, 2'b00); chk_all("post_rst", 2'b10, 0, 1, 0, 1, 2'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
